udp_top_hls_deadlock_reporter: RTL and testbench

//  Sits directly downstream of the udp_top dataflow deadlock monitor. Consumes its raw
//  per-cycle block flag plus the raw inst/axis block vectors. Filters transient stalls:

---
 rtl/udp_top_hls_deadlock_reporter.sv | 111 +++++++++++
 tb/tb_udp_top_hls_deadlock_reporter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_top_hls_deadlock_reporter.sv
// Debounces the udp_top dataflow monitor's raw block flag into deadlock declarations,
// capturing a snapshot of the stalled processes/streams and episode statistics.
module udp_top_hls_deadlock_reporter #(
   parameter int unsigned THRESHOLD = 1024,
   parameter int unsigned NUM_INST  = 11,
   parameter int unsigned NUM_AXIS  = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                block,
   input  logic [NUM_INST-1:0] inst_block_sigs,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic                clear,
   output logic                deadlock,
   output logic                deadlock_pulse,
   output logic [NUM_INST-1:0] snap_inst_block,
   output logic [NUM_AXIS-1:0] snap_axis_block,
   output logic [CNT_W-1:0]    event_count,
   output logic [31:0]         stall_cycles
);

   localparam int unsigned PW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
   localparam logic [PW-1:0] PLAST = PW'(THRESHOLD - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      DETECTED = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] pcount;
   logic          declare;

   // A declaration happens on the edge that completes THRESHOLD consecutive high samples.
   always_comb begin
      declare = 1'b0;
      if (block) begin
         if (state == IDLE && THRESHOLD == 1)
            declare = 1'b1;
         else if (state == PENDING && pcount == PLAST)
            declare = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state           <= IDLE;
         pcount          <= '0;
         deadlock        <= 1'b0;
         deadlock_pulse  <= 1'b0;
         snap_inst_block <= '0;
         snap_axis_block <= '0;
         event_count     <= '0;
         stall_cycles    <= '0;
      end else begin
         deadlock_pulse <= declare;

         case (state)
            IDLE: begin
               if (block) begin
                  if (THRESHOLD == 1) begin
                     state  <= DETECTED;
                     pcount <= '0;
                  end else begin
                     state  <= PENDING;
                     pcount <= PW'(1);
                  end
               end
            end
            PENDING: begin
               if (!block) begin
                  state  <= IDLE;
                  pcount <= '0;
               end else if (pcount == PLAST) begin
                  state  <= DETECTED;
                  pcount <= '0;
               end else begin
                  pcount <= pcount + PW'(1);
               end
            end
            DETECTED: begin
               if (!block)
                  state <= IDLE;
               else if (stall_cycles != '1)
                  stall_cycles <= stall_cycles + 32'd1;
            end
            default: begin
               state  <= IDLE;
               pcount <= '0;
            end
         endcase

         if (declare) begin
            snap_inst_block <= inst_block_sigs;
            snap_axis_block <= axis_block_sigs;
            stall_cycles    <= 32'(THRESHOLD);
            if (event_count != '1)
               event_count <= event_count + CNT_W'(1);
         end

         // Set has priority over a coincident clear.
         if (declare)
            deadlock <= 1'b1;
         else if (clear)
            deadlock <= 1'b0;
      end
   end

endmodule

// File: tb/tb_udp_top_hls_deadlock_reporter.sv
// Bench for udp_top_hls_deadlock_reporter: directed scenarios plus randomized run-length model checks.
module tb_udp_top_hls_deadlock_reporter;

   localparam int TH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        block = 1'b0;
   logic [10:0] inst_block_sigs = '0;
   logic [7:0]  axis_block_sigs = '0;
   logic        clear = 1'b0;

   logic        deadlock, deadlock_pulse;
   logic [10:0] snap_inst_block;
   logic [7:0]  snap_axis_block;
   logic [15:0] event_count;
   logic [31:0] stall_cycles;

   logic        s_deadlock, s_pulse;
   logic [10:0] s_snap_inst;
   logic [7:0]  s_snap_axis;
   logic [1:0]  s_event_count;
   logic [31:0] s_stall;

   udp_top_hls_deadlock_reporter #(.THRESHOLD(TH), .NUM_INST(11), .NUM_AXIS(8), .CNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n), .block(block),
      .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs), .clear(clear),
      .deadlock(deadlock), .deadlock_pulse(deadlock_pulse),
      .snap_inst_block(snap_inst_block), .snap_axis_block(snap_axis_block),
      .event_count(event_count), .stall_cycles(stall_cycles)
   );

   udp_top_hls_deadlock_reporter #(.THRESHOLD(TH), .NUM_INST(11), .NUM_AXIS(8), .CNT_W(2)) dut_sat (
      .clock(clock), .reset_n(reset_n), .block(block),
      .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs), .clear(clear),
      .deadlock(s_deadlock), .deadlock_pulse(s_pulse),
      .snap_inst_block(s_snap_inst), .snap_axis_block(s_snap_axis),
      .event_count(s_event_count), .stall_cycles(s_stall)
   );

   always #5 clock = ~clock;

   int passed = 0;
   int total  = 0;
   int pulses_seen = 0;

   // Reference model: length of the current run of high block samples since reset.
   int          m_run = 0;
   logic        m_dead = 0, m_pulse = 0;
   logic [10:0] m_snap_i = '0;
   logic [7:0]  m_snap_a = '0;
   int          m_cnt = 0;
   longint      m_stall = 0;

   function automatic logic [15:0] exp_cnt16();
      return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
   endfunction

   function automatic logic [1:0] exp_cnt2();
      return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
   endfunction

   task automatic cycle(input logic b, input logic [10:0] i, input logic [7:0] a,
                        input logic c, input logic rn);
      block = b; inst_block_sigs = i; axis_block_sigs = a; clear = c; reset_n = rn;
      @(posedge clock);
      if (!rn) begin
         m_run = 0; m_dead = 0; m_pulse = 0; m_snap_i = '0; m_snap_a = '0;
         m_cnt = 0; m_stall = 0;
      end else begin
         m_pulse = 0;
         if (b) begin
            if (m_run <= TH) m_run++;
            if (m_run == TH) begin
               m_pulse = 1; m_snap_i = i; m_snap_a = a; m_cnt++; m_stall = TH;
            end else if (m_run > TH) begin
               if (m_stall < 64'hFFFF_FFFF) m_stall++;
            end
         end else begin
            m_run = 0;
         end
         if (m_pulse) m_dead = 1;
         else if (c) m_dead = 0;
      end
      #1;
      if (s_pulse) pulses_seen++;
   endtask

   task automatic do_reset();
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 11'h7FF, 8'hFF, 1'b0, 1'b0);
      cycle(1'b1, 11'h7FF, 8'hFF, 1'b0, 1'b0);
      total++;
      if ({deadlock, deadlock_pulse, snap_inst_block, snap_axis_block, event_count, stall_cycles} !== '0)
         $display("FAIL reset_outputs: got dl=%b p=%b si=%h sa=%h ec=%0d sc=%0d, want all 0",
                  deadlock, deadlock_pulse, snap_inst_block, snap_axis_block, event_count, stall_cycles);
      else passed++;
      total++;
      if ({s_deadlock, s_pulse, s_event_count, s_stall} !== '0)
         $display("FAIL reset_outputs_sat: got dl=%b p=%b ec=%0d sc=%0d, want all 0",
                  s_deadlock, s_pulse, s_event_count, s_stall);
      else passed++;
   endtask

   task automatic test_short_stall();
      int bad = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 11'($urandom), 8'($urandom), 1'b0, 1'b1);
         if (deadlock !== 1'b0 || deadlock_pulse !== 1'b0) bad++;
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      if (deadlock !== 1'b0 || deadlock_pulse !== 1'b0) bad++;
      total++;
      if (bad != 0) $display("FAIL short_no_deadlock: %0d cycles showed deadlock/pulse, want 0", bad);
      else passed++;
      total++;
      if (event_count !== 16'd0) $display("FAIL short_event_count: got %0d want 0", event_count);
      else passed++;
   endtask

   task automatic test_declare();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 11'($urandom), 8'($urandom), 1'b0, 1'b1);
         total++;
         if (deadlock !== 1'b0) $display("FAIL declare_early: edge %0d got dl=%b want 0", k + 1, deadlock);
         else passed++;
      end
      cycle(1'b1, 11'h155, 8'hA5, 1'b0, 1'b1);
      total++;
      if (deadlock !== 1'b1 || deadlock_pulse !== 1'b1)
         $display("FAIL declare_flag: got dl=%b p=%b want 1 1", deadlock, deadlock_pulse);
      else passed++;
      total++;
      if (snap_inst_block !== 11'h155 || snap_axis_block !== 8'hA5)
         $display("FAIL declare_snap: got inst=%h axis=%h want 155 a5", snap_inst_block, snap_axis_block);
      else passed++;
      total++;
      if (event_count !== 16'd1 || stall_cycles !== 32'd4)
         $display("FAIL declare_stats: got ec=%0d sc=%0d want 1 4", event_count, stall_cycles);
      else passed++;
      cycle(1'b1, 11'h0AA, 8'h5A, 1'b0, 1'b1);
      total++;
      if (deadlock_pulse !== 1'b0 || deadlock !== 1'b1 || snap_inst_block !== 11'h155)
         $display("FAIL declare_pulse_width: got p=%b dl=%b si=%h want 0 1 155",
                  deadlock_pulse, deadlock, snap_inst_block);
      else passed++;
   endtask

   task automatic test_long_stall();
      int p0;
      do_reset();
      p0 = pulses_seen;
      for (int k = 0; k < 10; k++) cycle(1'b1, 11'($urandom), 8'($urandom), 1'b0, 1'b1);
      total++;
      if (stall_cycles !== 32'd10) $display("FAIL long_stall_len: got %0d want 10", stall_cycles);
      else passed++;
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      total++;
      if (stall_cycles !== 32'd10 || event_count !== 16'd1)
         $display("FAIL long_stall_freeze: got sc=%0d ec=%0d want 10 1", stall_cycles, event_count);
      else passed++;
      total++;
      if (pulses_seen - p0 != 1) $display("FAIL long_single_pulse: got %0d pulses want 1", pulses_seen - p0);
      else passed++;
   endtask

   task automatic test_clear();
      int p0;
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, 11'h001, 8'h01, 1'b0, 1'b1);
      p0 = pulses_seen;
      cycle(1'b1, 11'h002, 8'h02, 1'b1, 1'b1);
      cycle(1'b1, 11'h003, 8'h03, 1'b0, 1'b1);
      cycle(1'b1, 11'h004, 8'h04, 1'b1, 1'b1);
      total++;
      if (deadlock !== 1'b0 || pulses_seen != p0 || snap_inst_block !== 11'h001)
         $display("FAIL clear_held_block: got dl=%b extra_pulses=%0d si=%h want 0 0 001",
                  deadlock, pulses_seen - p0, snap_inst_block);
      else passed++;
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) cycle(1'b1, '0, '0, 1'b0, 1'b1);
      // Declaration edge coincides with clear: the set must win.
      cycle(1'b1, 11'h3C3, 8'h3C, 1'b1, 1'b1);
      total++;
      if (deadlock !== 1'b1 || event_count !== 16'd2 || snap_axis_block !== 8'h3C)
         $display("FAIL clear_rearm: got dl=%b ec=%0d sa=%h want 1 2 3c", deadlock, event_count, snap_axis_block);
      else passed++;
   endtask

   task automatic test_saturate();
      int p0;
      do_reset();
      p0 = pulses_seen;
      for (int e = 0; e < 5; e++) begin
         for (int k = 0; k < 4; k++) cycle(1'b1, 11'($urandom), 8'($urandom), 1'b0, 1'b1);
         cycle(1'b0, '0, '0, 1'b0, 1'b1);
      end
      total++;
      if (s_event_count !== 2'd3) $display("FAIL sat_event_count: got %0d want 3", s_event_count);
      else passed++;
      total++;
      if (event_count !== 16'd5) $display("FAIL wide_event_count: got %0d want 5", event_count);
      else passed++;
      total++;
      if (pulses_seen - p0 != 5) $display("FAIL sat_pulses: got %0d want 5", pulses_seen - p0);
      else passed++;
   endtask

   task automatic test_reset_mid_episode();
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, '0, '0, 1'b0, 1'b1);
      cycle(1'b1, 11'h7FF, 8'hFF, 1'b0, 1'b0);
      total++;
      if ({deadlock, deadlock_pulse, event_count, stall_cycles} !== '0)
         $display("FAIL midreset_outputs: got dl=%b p=%b ec=%0d sc=%0d want 0", deadlock,
                  deadlock_pulse, event_count, stall_cycles);
      else passed++;
      for (int k = 0; k < 3; k++) cycle(1'b1, '0, '0, 1'b0, 1'b1);
      total++;
      if (deadlock !== 1'b0) $display("FAIL midreset_no_early: got dl=%b want 0", deadlock);
      else passed++;
      cycle(1'b1, 11'h123, 8'h45, 1'b0, 1'b1);
      total++;
      if (deadlock !== 1'b1 || event_count !== 16'd1)
         $display("FAIL midreset_declare: got dl=%b ec=%0d want 1 1", deadlock, event_count);
      else passed++;
   endtask

   task automatic test_random();
      logic b, c, rn;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         b  = ($urandom_range(0, 9) < 8);
         c  = ($urandom_range(0, 15) == 0);
         rn = ($urandom_range(0, 199) != 0);
         cycle(b, 11'($urandom), 8'($urandom), c, rn);
         total++;
         if (deadlock !== m_dead || deadlock_pulse !== m_pulse || snap_inst_block !== m_snap_i ||
             snap_axis_block !== m_snap_a || event_count !== exp_cnt16() ||
             stall_cycles !== 32'(m_stall) || s_event_count !== exp_cnt2())
            $display("FAIL random_cycle%0d: got dl=%b p=%b si=%h sa=%h ec=%0d sc=%0d sec=%0d want %b %b %h %h %0d %0d %0d",
                     n, deadlock, deadlock_pulse, snap_inst_block, snap_axis_block, event_count,
                     stall_cycles, s_event_count, m_dead, m_pulse, m_snap_i, m_snap_a,
                     exp_cnt16(), 32'(m_stall), exp_cnt2());
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_short_stall();
      test_declare();
      test_long_stall();
      test_clear();
      test_saturate();
      test_reset_mid_episode();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
